// File: rtl/scalar_multiplicator_stream_pkg.sv
// Shared definitions for the scalar_multiplicator_stream block.
//   - Opcode encodings accepted on Operation while the block is idle.
//   - FSM state type, also exported on the interface as a debug signal.
//   - Helpers for opcode decode and index-width sizing.
package scalar_multiplicator_stream_pkg;

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_MUL_WRAP = 3'b001;
    localparam logic [2:0] OP_MUL_SAT  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True for the two opcodes that launch an operation.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == OP_MUL_WRAP) || (op == OP_MUL_SAT);
    endfunction

    // OutIndex width. A single-row configuration still carries a one-bit index
    // so that no zero-width vectors appear anywhere.
    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/scalar_multiplicator_stream_if.sv
// Bus interface of scalar_multiplicator_stream.
//   master : the CPU / stream source-sink side (drives Operation, Scalar, InValid,
//            InRow, OutReady)
//   slave  : the multiplier block (drives InReady, OutValid, OutRow, OutIndex,
//            Busy, Done, Error, Saturated, dbg_state)
// Handshake rule for both streams: a row moves on a rising edge exactly when
// valid and ready are both high in the cycle before that edge. The producer
// must hold its data stable while valid is high and ready is low; ready may be
// driven combinationally, valid never depends on ready.
interface scalar_multiplicator_stream_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int ROWS  = 4
);
    import scalar_multiplicator_stream_pkg::*;

    localparam int IDX_W = idx_width(ROWS);

    logic [2:0]             Operation;
    logic [WIDTH-1:0]       Scalar;
    logic                   InValid;
    logic                   InReady;
    logic [LANES*WIDTH-1:0] InRow;
    logic                   OutValid;
    logic                   OutReady;
    logic [LANES*WIDTH-1:0] OutRow;
    logic [IDX_W-1:0]       OutIndex;
    logic                   Busy;
    logic                   Done;
    logic                   Error;
    logic                   Saturated;
    state_t                 dbg_state;

    modport master (
        output Operation, Scalar, InValid, InRow, OutReady,
        input  InReady, OutValid, OutRow, OutIndex, Busy, Done, Error, Saturated,
               dbg_state
    );

    modport slave (
        input  Operation, Scalar, InValid, InRow, OutReady,
        output InReady, OutValid, OutRow, OutIndex, Busy, Done, Error, Saturated,
               dbg_state
    );

endinterface

// File: rtl/scalar_multiplicator_stream_lane.sv
// One lane of the row multiplier: a PIPE_STAGES-deep registered signed
// WIDTHxWIDTH multiply. The last product register feeds the overflow detector
// and the wrap/saturate mux, so the lane result is glitch-free and holds while
// the pipeline is frozen.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : advance the pipeline (low = freeze)
//   sat_i      : 1 = clamp on overflow, 0 = keep the low WIDTH bits
//   elem_i     : signed input element
//   scalar_i   : signed scalar
//   res_o      : lane result of the product in the last stage
//   ovf_o      : that product does not fit in WIDTH signed bits
module scalar_multiplicator_stream_lane #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    sat_i,
    input  logic signed [WIDTH-1:0] elem_i,
    input  logic signed [WIDTH-1:0] scalar_i,
    output logic [WIDTH-1:0]        res_o,
    output logic                    ovf_o
);
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] elem_x;
    logic signed [PW-1:0] scalar_x;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q [PIPE_STAGES];
    logic signed [PW-1:0] p_last;

    // Sign-extend both operands to the full product width so the multiply is
    // done at 2*WIDTH bits with no implicit context extension.
    always_comb begin
        elem_x   = {{WIDTH{elem_i[WIDTH-1]}}, elem_i};
        scalar_x = {{WIDTH{scalar_i[WIDTH-1]}}, scalar_i};
        prod_d   = elem_x * scalar_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= '0;
        end else if (en_i) begin
            prod_q[0] <= prod_d;
            for (int i = 1; i < PIPE_STAGES; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    // The product fits iff its top WIDTH+1 bits are all copies of the sign.
    always_comb begin
        p_last = prod_q[PIPE_STAGES-1];
        ovf_o  = ~((&p_last[PW-1:WIDTH-1]) | ~(|p_last[PW-1:WIDTH-1]));
        res_o  = p_last[WIDTH-1:0];
        if (ovf_o && sat_i) res_o = p_last[PW-1] ? S_MIN : S_MAX;
    end

endmodule

// File: rtl/scalar_multiplicator_stream.sv
// Matrix-by-scalar multiplier: latches a signed scalar on a start opcode, then
// streams ROWS rows of LANES signed elements through a PIPE_STAGES-deep
// multiplier with valid/ready on both sides. Wrap mode flags overflow on Error;
// saturate mode clamps and flags Saturated.
//   Clock      : rising-edge clock
//   ClearAll_n : asynchronous active-low reset
//   bus        : slave side of scalar_multiplicator_stream_if (opcode, scalar,
//                input/output row streams, status flags, debug state)
module scalar_multiplicator_stream
    import scalar_multiplicator_stream_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LANES       = 4,
    parameter int ROWS        = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                         Clock,
    input  logic                         ClearAll_n,
    scalar_multiplicator_stream_if.slave bus
);
    localparam int IDX_W = idx_width(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] ROWS_C   = CNT_W'(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  scalar_q, scalar_d;
    logic                     sat_mode_q, sat_mode_d;
    logic                     err_q, err_d;
    logic                     sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]         rows_in_q, rows_in_d;

    // Valid and row-index chains run alongside the lane pipelines.
    logic                     vld_q [PIPE_STAGES];
    logic [IDX_W-1:0]         idx_q [PIPE_STAGES];

    logic                     out_valid;
    logic                     stall;
    logic                     in_ready;
    logic                     in_fire;
    logic                     out_fire;
    logic [LANES-1:0]         lane_ovf;
    logic [WIDTH-1:0]         lane_res [LANES];
    logic [LANES*WIDTH-1:0]   out_row;

    // A waiting output row freezes every stage, so nothing is overwritten and
    // bubbles are never squeezed out.
    assign out_valid = vld_q[PIPE_STAGES-1];
    assign stall     = out_valid & ~bus.OutReady;
    assign in_ready  = (state_q == S_RUN) & ~stall & (rows_in_q < ROWS_C);
    assign in_fire   = bus.InValid & in_ready;
    assign out_fire  = out_valid & bus.OutReady;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        scalar_multiplicator_stream_lane #(
            .WIDTH      (WIDTH),
            .PIPE_STAGES(PIPE_STAGES)
        ) u_lane (
            .clk     (Clock),
            .rst_n   (ClearAll_n),
            .en_i    (~stall),
            .sat_i   (sat_mode_q),
            .elem_i  (bus.InRow[k*WIDTH +: WIDTH]),
            .scalar_i(scalar_q),
            .res_o   (lane_res[k]),
            .ovf_o   (lane_ovf[k])
        );
        assign out_row[k*WIDTH +: WIDTH] = lane_res[k];
    end

    always_comb begin
        state_d    = state_q;
        scalar_d   = scalar_q;
        sat_mode_d = sat_mode_q;
        err_d      = err_q;
        sat_flag_d = sat_flag_q;
        rows_in_d  = rows_in_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_start_op(bus.Operation)) begin
                    state_d    = S_RUN;
                    scalar_d   = bus.Scalar;
                    sat_mode_d = (bus.Operation == OP_MUL_SAT);
                    err_d      = 1'b0;
                    sat_flag_d = 1'b0;
                    rows_in_d  = '0;
                end else if (bus.Operation != OP_NOP) begin
                    err_d = 1'b1;
                end
            end
            S_RUN: begin
                if (in_fire) rows_in_d = rows_in_q + CNT_W'(1);
                // Flags reflect a row only once it leaves the block.
                if (out_fire) begin
                    if (|lane_ovf) begin
                        if (sat_mode_q) sat_flag_d = 1'b1;
                        else            err_d      = 1'b1;
                    end
                    if (idx_q[PIPE_STAGES-1] == LAST_IDX) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            state_q    <= S_IDLE;
            scalar_q   <= '0;
            sat_mode_q <= 1'b0;
            err_q      <= 1'b0;
            sat_flag_q <= 1'b0;
            rows_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            scalar_q   <= scalar_d;
            sat_mode_q <= sat_mode_d;
            err_q      <= err_d;
            sat_flag_q <= sat_flag_d;
            rows_in_q  <= rows_in_d;
        end
    end

    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                vld_q[i] <= 1'b0;
                idx_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_fire;
            idx_q[0] <= rows_in_q[IDX_W-1:0];
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign bus.InReady   = in_ready;
    assign bus.OutValid  = out_valid;
    assign bus.OutRow    = out_row;
    assign bus.OutIndex  = idx_q[PIPE_STAGES-1];
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Done      = (state_q == S_DONE);
    assign bus.Error     = err_q;
    assign bus.Saturated = sat_flag_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_scalar_multiplicator_stream.sv
module tb_scalar_multiplicator_stream;
  localparam int W     = 32;
  localparam int L     = 4;
  localparam int R     = 4;
  localparam int P     = 2;
  localparam int IDX_W = 2;
  localparam int RW    = L * W;
  localparam int CW    = RW + IDX_W;

  logic clk;
  logic rst_n;

  scalar_multiplicator_stream_if #(.WIDTH(W), .LANES(L), .ROWS(R)) bus ();

  scalar_multiplicator_stream #(
    .WIDTH(W), .LANES(L), .ROWS(R), .PIPE_STAGES(P)
  ) dut (
    .Clock     (clk),
    .ClearAll_n(rst_n),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  logic [CW-1:0] exp_q[$];
  logic [RW-1:0] in_tab [R];
  logic [RW-1:0] exp_tab [R];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  int first_out_cyc = -1;
  int last_accept_cyc = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // monitor: pops the expected queue on every output handshake
  always @(negedge clk) begin
    logic [CW-1:0] e;
    if (bus.Done) done_cnt++;
    if (bus.OutValid && bus.OutReady) begin
      out_cnt++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got %h with empty queue", bus.OutRow);
      end else begin
        e = exp_q.pop_front();
        check("out_row", CW'(bus.OutRow), CW'(e[RW-1:0]));
        check("out_index", CW'(bus.OutIndex), CW'(e[CW-1:RW]));
      end
    end
  end

  // driver tasks (all called right after a rising edge)
  task automatic start_op(input logic [2:0] op, input logic [31:0] s);
    bus.Operation = op;
    bus.Scalar = s;
    @(posedge clk); #1;
    bus.Operation = 3'b000;
  endtask

  task automatic send_row(input logic [RW-1:0] r, input logic [RW-1:0] e, input int idx);
    int t = 0;
    bit ok = 0;
    logic [IDX_W-1:0] ix;
    ix = idx[IDX_W-1:0];
    bus.InValid = 1'b1;
    bus.InRow = r;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.InReady) begin
        ok = 1;
        last_accept_cyc = cyc;
        exp_q.push_back({ix, e});
      end
      @(posedge clk); #1;
      t++;
    end
    bus.InValid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: row %0d got no InReady expected accept", idx);
    end
  endtask

  task automatic send_rows();
    for (int i = 0; i < R; i++) send_row(in_tab[i], exp_tab[i], i);
  endtask

  // waits for Done; checks end-of-op flags at that cycle
  task automatic wait_done(input string tag, input logic exp_err, input logic exp_sat);
    int t = 0;
    bit ok = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.Done) ok = 1;
      else t++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no Done expected pulse", tag);
    end else begin
      check({tag, "_error"}, CW'(bus.Error), CW'(exp_err));
      check({tag, "_saturated"}, CW'(bus.Saturated), CW'(exp_sat));
      check({tag, "_outvalid_dropped"}, CW'(bus.OutValid), '0);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, CW'(bus.Done), '0);
    check({tag, "_busy_after"}, CW'(bus.Busy), '0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    rst_n = 1'b0;
    bus.Operation = 3'b000;
    bus.Scalar = '0;
    bus.InValid = 1'b0;
    bus.InRow = '0;
    bus.OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", CW'(bus.Busy), '0);
    check("rst_outvalid", CW'(bus.OutValid), '0);
    check("rst_inready", CW'(bus.InReady), '0);
    check("rst_flags", CW'({bus.Done, bus.Error, bus.Saturated}), '0);
    check("rst_outrow", CW'(bus.OutRow), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: wrap, scalar -5, rows of 4 -> -20, latency 2
    for (int i = 0; i < R; i++) begin
      in_tab[i] = pack(32'd4, 32'd4, 32'd4, 32'd4);
      exp_tab[i] = pack(-32'sd20, -32'sd20, -32'sd20, -32'sd20);
    end
    first_out_cyc = -1;
    d0 = done_cnt;
    start_op(3'b001, -32'sd5);
    check("t1_busy", CW'(bus.Busy), CW'(1));
    send_row(in_tab[0], exp_tab[0], 0);
    begin
      int a0;
      a0 = last_accept_cyc;
      for (int i = 1; i < R; i++) send_row(in_tab[i], exp_tab[i], i);
      wait_done("t1", 1'b0, 1'b0);
      check("t1_latency", CW'(first_out_cyc - a0), CW'(2));
    end
    check("t1_done_count", CW'(done_cnt - d0), CW'(1));

    // 2: wrap overflow in lane 0
    in_tab[0] = pack(32'd65536, 32'd1, 32'd2, 32'd3);
    exp_tab[0] = pack(32'd0, 32'd65536, 32'd131072, 32'd196608);
    for (int i = 1; i < R; i++) begin
      in_tab[i] = pack(32'd1, 32'd1, 32'd1, 32'd1);
      exp_tab[i] = pack(32'd65536, 32'd65536, 32'd65536, 32'd65536);
    end
    start_op(3'b001, 32'd65536);
    send_rows();
    wait_done("t2", 1'b1, 1'b0);

    // 3: saturate mode
    in_tab[0] = pack(32'h7FFFFFFF, 32'h80000001, 32'h80000000, 32'd7);
    exp_tab[0] = pack(32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'd14);
    in_tab[1] = pack(32'd1, 32'd2, 32'd3, 32'd4);
    exp_tab[1] = pack(32'd2, 32'd4, 32'd6, 32'd8);
    in_tab[2] = pack(-32'sd1, -32'sd2, 32'h3FFFFFFF, 32'hC0000000);
    exp_tab[2] = pack(-32'sd2, -32'sd4, 32'h7FFFFFFE, 32'h80000000);
    in_tab[3] = pack(32'h40000000, 32'd0, 32'd100, -32'sd100);
    exp_tab[3] = pack(32'h7FFFFFFF, 32'd0, 32'd200, -32'sd200);
    start_op(3'b010, 32'd2);
    send_rows();
    wait_done("t3", 1'b0, 1'b1);

    // 4: 5-cycle output stall mid-stream
    in_tab[0] = pack(32'd0, 32'd10, 32'd0, 32'd100);
    exp_tab[0] = pack(32'd0, 32'd30, 32'd0, 32'd300);
    in_tab[1] = pack(32'd1, 32'd11, -32'sd1, 32'd100);
    exp_tab[1] = pack(32'd3, 32'd33, -32'sd3, 32'd300);
    in_tab[2] = pack(32'd2, 32'd12, -32'sd2, 32'd100);
    exp_tab[2] = pack(32'd6, 32'd36, -32'sd6, 32'd300);
    in_tab[3] = pack(32'd3, 32'd13, -32'sd3, 32'd100);
    exp_tab[3] = pack(32'd9, 32'd39, -32'sd9, 32'd300);
    start_op(3'b001, 32'd3);
    d0 = out_cnt;
    fork
      send_rows();
      begin : staller
        int t;
        t = 0;
        while (out_cnt < d0 + 1 && t < 50) begin
          @(posedge clk);
          t++;
        end
        #1 bus.OutReady = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_inready", CW'(bus.InReady), '0);
          check("stall_outvalid", CW'(bus.OutValid), CW'(1));
          if (exp_q.size() > 0) begin
            check("stall_row", CW'(bus.OutRow), CW'(exp_q[0][RW-1:0]));
            check("stall_index", CW'(bus.OutIndex), CW'(exp_q[0][CW-1:RW]));
          end
          @(posedge clk);
        end
        #1 bus.OutReady = 1'b1;
      end
    join
    wait_done("t4", 1'b0, 1'b0);
    check("t4_rows_out", CW'(out_cnt - d0), CW'(R));

    // 5: illegal opcode, then legal start with scalar 0
    bus.Operation = 3'b111;
    @(posedge clk); #1;
    bus.Operation = 3'b000;
    @(negedge clk);
    check("t5_error_set", CW'(bus.Error), CW'(1));
    check("t5_busy", CW'(bus.Busy), '0);
    check("t5_inready", CW'(bus.InReady), '0);
    @(posedge clk); @(negedge clk);
    check("t5_error_sticky", CW'(bus.Error), CW'(1));
    @(posedge clk); #1;
    for (int i = 0; i < R; i++) begin
      in_tab[i] = pack(32'h7FFFFFFF, 32'h80000000, -32'sd9, 32'd5);
      exp_tab[i] = '0;
    end
    start_op(3'b001, 32'd0);
    @(negedge clk);
    check("t5_error_cleared", CW'(bus.Error), '0);
    @(posedge clk); #1;
    send_rows();
    wait_done("t5", 1'b0, 1'b0);

    // 7: scalar -1, min * -1 overflows in wrap mode
    in_tab[0] = pack(32'h80000000, 32'd5, -32'sd7, 32'd0);
    exp_tab[0] = pack(32'h80000000, -32'sd5, 32'd7, 32'd0);
    for (int i = 1; i < R; i++) begin
      in_tab[i] = pack(32'd1, 32'h7FFFFFFF, 32'h80000001, -32'sd1);
      exp_tab[i] = pack(-32'sd1, 32'h80000001, 32'h7FFFFFFF, 32'd1);
    end
    start_op(3'b001, -32'sd1);
    send_rows();
    wait_done("t7", 1'b1, 1'b0);

    // 6: async reset after two accepted rows
    for (int i = 0; i < R; i++) begin
      in_tab[i] = pack(32'd1, 32'd2, 32'd3, 32'd4);
      exp_tab[i] = pack(32'd7, 32'd14, 32'd21, 32'd28);
    end
    start_op(3'b001, 32'd7);
    send_row(in_tab[0], exp_tab[0], 0);
    send_row(in_tab[1], exp_tab[1], 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #2;
    check("t6_rst_busy", CW'(bus.Busy), '0);
    check("t6_rst_outvalid", CW'(bus.OutValid), '0);
    check("t6_rst_outrow", CW'(bus.OutRow), '0);
    check("t6_rst_flags", CW'({bus.Done, bus.Error, bus.Saturated, bus.InReady}), '0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_done", CW'(done_cnt - d0), '0);
    start_op(3'b001, 32'd7);
    send_rows();
    wait_done("t6", 1'b0, 1'b0);
    check("t6_done_count", CW'(done_cnt - d0), CW'(1));

    repeat (3) @(posedge clk);
    check("final_queue_empty", CW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
